// File: rtl/change_dispenser_ctrl.sv
// change_dispenser_ctrl
//   Pays out a change/refund total (Q1: 1 LSB = 0.5 yuan) one coin at a time.
//   Greedy selection uses 1-yuan coins first, then 0.5-yuan coins. Each coin
//   is handshaked with the hopper sensor. Per-denomination stock is tracked,
//   and the block flags a shortfall or a hopper timeout.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high (also reloads inventories)
//   start        one-cycle pulse: begin paying out 'amount' (accepted in IDLE only)
//   amount       payout value, Q1
//   refill       one-cycle pulse: reload inventories (accepted in IDLE only)
//   hopper_ack   one-cycle pulse: coin sensed leaving the hopper
//   eject_1      one-cycle pulse: eject one 1-yuan coin
//   eject_05     one-cycle pulse: eject one 0.5-yuan coin
//   busy         high in every state except IDLE
//   done         one-cycle pulse: payout finished (complete or short)
//   short_flag   last payout could not be completed; cleared by next accepted start
//   fault        hopper timeout; sticky until rst
//   remaining    Q1 value still owed
//   inv_1        1-yuan coins in stock
//   inv_05       0.5-yuan coins in stock
module change_dispenser_ctrl #(
  parameter int unsigned W       = 6,
  parameter int unsigned INV_W   = 8,
  parameter int unsigned INIT_1Y = 20,
  parameter int unsigned INIT_05 = 20,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     amount,
  input  logic             refill,
  input  logic             hopper_ack,
  output logic             eject_1,
  output logic             eject_05,
  output logic             busy,
  output logic             done,
  output logic             short_flag,
  output logic             fault,
  output logic [W-1:0]     remaining,
  output logic [INV_W-1:0] inv_1,
  output logic [INV_W-1:0] inv_05
);

  // Timer counts 0 .. TIMEOUT-1 while waiting for the hopper sensor.
  localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [INV_W-1:0] INV_1_RST  = INV_W'(INIT_1Y);
  localparam logic [INV_W-1:0] INV_05_RST = INV_W'(INIT_05);
  localparam logic [W-1:0]     Q_1Y       = W'(2);
  localparam logic [W-1:0]     Q_05       = W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               coin_1y_q;
  logic               coin_1y_d;
  logic [TMR_W-1:0]   timer_q;
  logic [TMR_W-1:0]   timer_d;
  logic [W-1:0]       remaining_d;
  logic [INV_W-1:0]   inv_1_d;
  logic [INV_W-1:0]   inv_05_d;
  logic               short_d;
  logic               eject_1_d;
  logic               eject_05_d;
  logic               busy_d;
  logic               done_d;
  logic               fault_d;

  // State and datapath registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      coin_1y_q  <= 1'b0;
      timer_q    <= '0;
      remaining  <= '0;
      inv_1      <= INV_1_RST;
      inv_05     <= INV_05_RST;
      short_flag <= 1'b0;
      eject_1    <= 1'b0;
      eject_05   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      coin_1y_q  <= coin_1y_d;
      timer_q    <= timer_d;
      remaining  <= remaining_d;
      inv_1      <= inv_1_d;
      inv_05     <= inv_05_d;
      short_flag <= short_d;
      eject_1    <= eject_1_d;
      eject_05   <= eject_05_d;
      busy       <= busy_d;
      done       <= done_d;
      fault      <= fault_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d     = state_q;
    coin_1y_d   = coin_1y_q;
    timer_d     = timer_q;
    remaining_d = remaining;
    inv_1_d     = inv_1;
    inv_05_d    = inv_05;
    short_d     = short_flag;
    eject_1_d   = 1'b0;
    eject_05_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Refill and start in the same cycle both take effect.
        if (refill) begin
          inv_1_d  = INV_1_RST;
          inv_05_d = INV_05_RST;
        end
        if (start) begin
          remaining_d = amount;
          short_d     = 1'b0;
          state_d     = SELECT;
        end
      end

      SELECT: begin
        // A coin is only chosen if it fits the amount owed and is in stock,
        // so neither remaining nor inventory can underflow.
        // The eject pulse is registered here so it lines up with EJECT.
        if (remaining == '0) begin
          state_d = DONE;
        end else if ((remaining >= Q_1Y) && (inv_1 != '0)) begin
          coin_1y_d = 1'b1;
          eject_1_d = 1'b1;
          state_d   = EJECT;
        end else if ((remaining >= Q_05) && (inv_05 != '0)) begin
          coin_1y_d  = 1'b0;
          eject_05_d = 1'b1;
          state_d    = EJECT;
        end else begin
          short_d = 1'b1;
          state_d = DONE;
        end
      end

      EJECT: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end

      WAIT_ACK: begin
        // An ack on the terminal timer cycle still counts.
        if (hopper_ack) begin
          if (coin_1y_q) begin
            remaining_d = remaining - Q_1Y;
            inv_1_d     = inv_1 - INV_W'(1);
          end else begin
            remaining_d = remaining - Q_05;
            inv_05_d    = inv_05 - INV_W'(1);
          end
          state_d = SELECT;
        end else if (timer_q == TMR_LAST) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      FAULT: begin
        // Frozen until rst.
        state_d = FAULT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    fault_d = (state_d == FAULT);
  end

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// tb_change_dispenser_ctrl
//   Self-checking bench for change_dispenser_ctrl. It uses a directed table
//   of payouts with hand-computed results and hand-written corner sequences
//   (idle ack, hopper timeout, reset mid-payout). It also runs randomized
//   payouts checked against a transaction-level greedy model.
module tb_change_dispenser_ctrl;

  localparam int unsigned W       = 6;
  localparam int unsigned INV_W   = 8;
  localparam int unsigned INIT_1Y = 20;
  localparam int unsigned INIT_05 = 20;
  localparam int unsigned TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     amount;
  logic             refill;
  logic             hopper_ack;
  logic             eject_1;
  logic             eject_05;
  logic             busy;
  logic             done;
  logic             short_flag;
  logic             fault;
  logic [W-1:0]     remaining;
  logic [INV_W-1:0] inv_1;
  logic [INV_W-1:0] inv_05;

  always #5 clk = ~clk;

  change_dispenser_ctrl #(
    .W(W), .INV_W(INV_W), .INIT_1Y(INIT_1Y), .INIT_05(INIT_05), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .refill(refill),
    .hopper_ack(hopper_ack), .eject_1(eject_1), .eject_05(eject_05),
    .busy(busy), .done(done), .short_flag(short_flag), .fault(fault),
    .remaining(remaining), .inv_1(inv_1), .inv_05(inv_05)
  );

  // One payout: stimulus (amount, ack delay, refill) and expected results.
  typedef struct {
    int amt;
    int dly;
    bit rfl;
    int n1;
    int n05;
    int rem;
    bit shrt;
    int inv1;
    int inv05;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   m_inv1;
  int   m_inv05;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_eject_1"}, int'(eject_1), 0);
    check({tag, "_eject_05"}, int'(eject_05), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_short"}, int'(short_flag), 0);
    check({tag, "_fault"}, int'(fault), 0);
    check({tag, "_remaining"}, int'(remaining), 0);
    check({tag, "_inv_1"}, int'(inv_1), int'(INIT_1Y));
    check({tag, "_inv_05"}, int'(inv_05), int'(INIT_05));
  endtask

  // Greedy payout computed with plain arithmetic: as many 1-yuan coins as
  // fit and are in stock, then 0.5-yuan coins for whatever is still owed.
  function automatic vec_t model(input int amt, input int dly, input bit rfl);
    vec_t v;
    int   i1;
    int   i05;
    int   r;
    i1      = rfl ? int'(INIT_1Y) : m_inv1;
    i05     = rfl ? int'(INIT_05) : m_inv05;
    v.amt   = amt;
    v.dly   = dly;
    v.rfl   = rfl;
    v.n1    = (amt / 2 < i1) ? amt / 2 : i1;
    r       = amt - 2 * v.n1;
    v.n05   = (r < i05) ? r : i05;
    v.rem   = r - v.n05;
    v.shrt  = (v.rem > 0);
    v.inv1  = i1 - v.n1;
    v.inv05 = i05 - v.n05;
    return v;
  endfunction

  // Runs one payout from IDLE. The hopper acks each coin v.dly cycles after
  // WAIT_ACK is entered. With stray set, a second start and a refill are
  // driven while the DUT is busy.
  task automatic run_payout(input vec_t v, input bit stray);
    int cyc;
    int ack_at;
    int paid;
    int n1;
    int n05;
    int first_ej;
    int done_cyc;
    bit seen_05;
    bit order_ok;
    cyc = 0; ack_at = -1; paid = 0; n1 = 0; n05 = 0;
    first_ej = -1; done_cyc = -1; seen_05 = 1'b0; order_ok = 1'b1;
    start  = 1'b1;
    amount = W'(v.amt);
    refill = v.rfl;
    while (done_cyc < 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; refill = 1'b0; hopper_ack = 1'b0;
      if (stray && cyc == 3) begin
        start  = 1'b1;
        amount = W'(v.amt ^ 63);
        refill = 1'b1;
      end
      if (eject_1 || eject_05) begin
        check("eject_remaining", int'(remaining), v.amt - paid);
        if (first_ej < 0) first_ej = cyc;
        if (eject_1) begin
          n1++; paid += 2;
          if (seen_05) order_ok = 1'b0;
        end else begin
          n05++; paid += 1; seen_05 = 1'b1;
        end
        ack_at = cyc + 1 + v.dly;
      end
      if (cyc == ack_at) hopper_ack = 1'b1;
      if (done) done_cyc = cyc;
    end
    check("done_seen", int'(done_cyc >= 0), 1);
    if (v.n1 + v.n05 > 0) check("first_eject_cycle", first_ej, 2);
    else                  check("done_cycle_no_coin", done_cyc, 2);
    check("n_eject_1", n1, v.n1);
    check("n_eject_05", n05, v.n05);
    check("coin_order", int'(order_ok), 1);
    check("final_remaining", int'(remaining), v.rem);
    check("short_flag", int'(short_flag), int'(v.shrt));
    check("inv_1", int'(inv_1), v.inv1);
    check("inv_05", int'(inv_05), v.inv05);
    @(posedge clk); #1;
    start = 1'b0; refill = 1'b0; hopper_ack = 1'b0;
    check("done_single_pulse", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    m_inv1  = v.inv1;
    m_inv05 = v.inv05;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    //            amt dly rfl n1 n05 rem shrt inv1 inv05
    tbl[0] = '{  5,  2, 0,  2,  1,  0, 0, 18, 19 };
    tbl[1] = '{ 20,  0, 0, 10,  0,  0, 0,  8, 19 };
    tbl[2] = '{  0,  0, 0,  0,  0,  0, 0,  8, 19 };
    tbl[3] = '{ 21,  1, 0,  8,  5,  0, 0,  0, 14 };
    tbl[4] = '{ 30,  0, 0,  0, 14, 16, 1,  0,  0 };
    tbl[5] = '{  1,  0, 0,  0,  0,  1, 1,  0,  0 };
    tbl[6] = '{  7,  3, 1,  3,  1,  0, 0, 17, 19 };
    tbl[7] = '{  2, 14, 0,  1,  0,  0, 0, 16, 19 };

    rst = 1'b1; start = 1'b0; amount = '0; refill = 1'b0; hopper_ack = 1'b0;
    m_inv1 = int'(INIT_1Y); m_inv05 = int'(INIT_05);
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Directed table; entry 1 also drives a stray start and refill while busy.
    for (int i = 0; i < 8; i++) run_payout(tbl[i], i == 1);

    // Stray hopper_ack while idle must not touch inventory.
    hopper_ack = 1'b1;
    @(posedge clk); #1;
    hopper_ack = 1'b0;
    @(posedge clk); #1;
    check("idle_ack_inv_1", int'(inv_1), m_inv1);
    check("idle_ack_inv_05", int'(inv_05), m_inv05);
    check("idle_ack_busy", int'(busy), 0);

    // Hopper never acks: fault after TIMEOUT cycles in WAIT_ACK, then frozen.
    begin
      int fcyc;
      int nej;
      fcyc = -1; nej = 0;
      start = 1'b1; amount = W'(4);
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        start = 1'b0; refill = 1'b0; hopper_ack = 1'b0;
        if (eject_1 || eject_05) nej++;
        if (fault && fcyc < 0) fcyc = c;
        if (fcyc >= 0) begin
          start = c[0]; refill = ~c[0]; hopper_ack = 1'b1; amount = W'(9);
        end
      end
      check("fault_cycle", fcyc, 3 + int'(TIMEOUT));
      check("fault_eject_count", nej, 1);
      check("fault_sticky", int'(fault), 1);
      check("fault_busy", int'(busy), 1);
      check("fault_done", int'(done), 0);
      check("fault_remaining", int'(remaining), 4);
      check("fault_inv_1", int'(inv_1), m_inv1);
      check("fault_inv_05", int'(inv_05), m_inv05);
      rst = 1'b1; start = 1'b0; refill = 1'b0; hopper_ack = 1'b0;
      @(posedge clk); #1;
      check_reset("fault_rst");
      rst = 1'b0;
      m_inv1 = int'(INIT_1Y); m_inv05 = int'(INIT_05);
    end

    // Reset during WAIT_ACK: immediate return to reset values, no re-eject.
    begin
      int nej;
      nej = 0;
      start = 1'b1; amount = W'(6);
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (c == 2) check("rstw_eject_1", int'(eject_1), 1);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset("rst_wait");
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (eject_1 || eject_05 || busy) nej++;
      end
      check("rstw_no_reissue", nej, 0);
    end

    // Randomized payouts against the greedy model.
    for (int t = 0; t < 40; t++) begin
      int   amt;
      int   dly;
      bit   rfl;
      bit   stray;
      vec_t v;
      amt   = int'($urandom_range(0, 63));
      dly   = int'($urandom_range(0, TIMEOUT - 1));
      rfl   = ($urandom_range(0, 5) == 0);
      v     = model(amt, dly, rfl);
      stray = (v.n1 + v.n05 > 0) && ($urandom_range(0, 3) == 0);
      run_payout(v, stray);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
